// File: rtl/sound_pwm_channel.sv
// Bus-mapped square-wave tone generator: period/compare timer with double-buffered reload,
// one-shot mode, tick prescaler and volume-scaled PCM output.
module sound_pwm_channel #(
    parameter logic [23:0] BASE_ADDR    = 24'h2070,
    parameter int unsigned PERIOD_WIDTH = 16,
    parameter int unsigned PRESCALE     = 1,
    parameter int unsigned AUDIO_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bus_write,
    input  logic [23:0]            bus_address_in,
    input  logic [7:0]             bus_data_in,
    output logic [7:0]             bus_data_out,
    output logic [AUDIO_WIDTH-1:0] audio_out,
    output logic                   wrap_pulse
);
    localparam int unsigned    PreW     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned    HiW      = PERIOD_WIDTH - 8;
    localparam int unsigned    VolShift = AUDIO_WIDTH - 3;
    localparam logic [PreW-1:0] PreMax  = PreW'(PRESCALE - 1);

    logic                    r_wr_en;
    logic [23:0]             r_wr_addr;
    logic [7:0]              r_wr_data;
    logic                    r_enable, r_oneshot;
    logic [2:0]              r_vol;
    logic [PERIOD_WIDTH-1:0] r_period_sh, r_cmp_sh, r_period_act, r_cmp_act, r_count;
    logic [PreW-1:0]         r_pre;
    logic                    r_wrap;
    logic [AUDIO_WIDTH-1:0]  r_audio;

    logic [23:0]             w_wr_diff, w_rd_diff;
    logic                    w_wr_hit, w_ctrl_wr, w_restart;
    logic [2:0]              w_wr_off;
    logic                    w_pre_last, w_tick, w_wrap, w_tone;
    logic [15:0]             w_period_ext, w_cmp_ext;

    // Unsigned difference: addresses below the base wrap to huge values and miss.
    assign w_wr_diff  = r_wr_addr - BASE_ADDR;
    assign w_wr_hit   = r_wr_en && (w_wr_diff < 24'd6);
    assign w_wr_off   = w_wr_diff[2:0];
    assign w_ctrl_wr  = w_wr_hit && (w_wr_off == 3'd0);
    assign w_restart  = w_ctrl_wr && r_wr_data[2];

    assign w_pre_last = (r_pre == PreMax);
    assign w_tick     = r_enable && w_pre_last;
    assign w_wrap     = w_tick && (r_count == r_period_act);
    assign w_tone     = r_enable && (r_count < r_cmp_act);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en   <= bus_write;
            r_wr_addr <= bus_address_in;
            r_wr_data <= bus_data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vol       <= '0;
            r_period_sh <= '0;
            r_cmp_sh    <= '0;
        end else if (w_wr_hit) begin
            case (w_wr_off)
                3'd1:    r_vol                        <= r_wr_data[2:0];
                3'd2:    r_period_sh[7:0]             <= r_wr_data;
                3'd3:    r_period_sh[PERIOD_WIDTH-1:8] <= r_wr_data[HiW-1:0];
                3'd4:    r_cmp_sh[7:0]                <= r_wr_data;
                3'd5:    r_cmp_sh[PERIOD_WIDTH-1:8]    <= r_wr_data[HiW-1:0];
                default: ;
            endcase
        end
    end

    // A CTRL write overrides the one-shot auto-disable on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_enable  <= 1'b0;
            r_oneshot <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_enable  <= r_wr_data[0];
            r_oneshot <= r_wr_data[1];
        end else if (w_wrap && r_oneshot) begin
            r_enable  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count      <= '0;
            r_pre        <= '0;
            r_period_act <= '0;
            r_cmp_act    <= '0;
            r_wrap       <= 1'b0;
        end else if (w_restart || !r_enable) begin
            r_count      <= '0;
            r_pre        <= '0;
            r_period_act <= r_period_sh;
            r_cmp_act    <= r_cmp_sh;
            r_wrap       <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            r_pre  <= w_pre_last ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                if (w_wrap) begin
                    r_count      <= '0;
                    r_period_act <= r_period_sh;
                    r_cmp_act    <= r_cmp_sh;
                    r_wrap       <= 1'b1;
                end else begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_audio <= '0;
        end else begin
            r_audio <= w_tone ? (AUDIO_WIDTH'(r_vol) << VolShift) : '0;
        end
    end

    assign w_rd_diff    = bus_address_in - BASE_ADDR;
    assign w_period_ext = 16'(r_period_sh);
    assign w_cmp_ext    = 16'(r_cmp_sh);

    always_comb begin
        bus_data_out = 8'd0;
        if (w_rd_diff < 24'd6) begin
            case (w_rd_diff[2:0])
                3'd0:    bus_data_out = {6'd0, r_oneshot, r_enable};
                3'd1:    bus_data_out = {5'd0, r_vol};
                3'd2:    bus_data_out = w_period_ext[7:0];
                3'd3:    bus_data_out = w_period_ext[15:8];
                3'd4:    bus_data_out = w_cmp_ext[7:0];
                3'd5:    bus_data_out = w_cmp_ext[15:8];
                default: bus_data_out = 8'd0;
            endcase
        end
    end

    assign audio_out  = r_audio;
    assign wrap_pulse = r_wrap;

endmodule

// File: tb/tb_sound_pwm_channel.sv
// Bench for sound_pwm_channel: two instances (default, and prescaled/narrow) on one bus,
// directed scenarios plus random bus traffic, checked against a cycle-level reference model.
module tb_sound_pwm_channel;
    localparam logic [23:0] Base = 24'h2070;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_write;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  rd0, rd1, au0;
    logic [5:0]  au1;
    logic        wp0, wp1;

    always #5 clk = ~clk;

    sound_pwm_channel #(.BASE_ADDR(Base)) u_dut0 (
        .clk(clk), .reset(reset), .bus_write(bus_write), .bus_address_in(bus_address_in),
        .bus_data_in(bus_data_in), .bus_data_out(rd0), .audio_out(au0), .wrap_pulse(wp0)
    );

    sound_pwm_channel #(.BASE_ADDR(Base), .PERIOD_WIDTH(12), .PRESCALE(4), .AUDIO_WIDTH(6))
    u_dut1 (
        .clk(clk), .reset(reset), .bus_write(bus_write), .bus_address_in(bus_address_in),
        .bus_data_in(bus_data_in), .bus_data_out(rd1), .audio_out(au1), .wrap_pulse(wp1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: per-instance parameters and architectural state.
    int m_ps[2] = '{1, 4};
    int m_pw[2] = '{16, 12};
    int m_aw[2] = '{8, 6};
    int en[2], os[2], vol[2], psh[2], csh[2], pact[2], cact[2], cnt[2], pre[2], wrp[2], aud[2];
    int p_v, p_a, p_d;

    function automatic bit in_map(input int a);
        return (a >= int'(Base)) && (a < int'(Base) + 6);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            en[k] = 0; os[k] = 0; vol[k] = 0; psh[k] = 0; csh[k] = 0;
            pact[k] = 0; cact[k] = 0; cnt[k] = 0; pre[k] = 0; wrp[k] = 0; aud[k] = 0;
        end
        p_v = 0; p_a = 0; p_d = 0;
    endtask

    task automatic step_inst(input int k, input int pv, input int pa, input int pd);
        bit hit, ctrl_w, restart, tick, wrapnow;
        int off, hmask;
        hit     = (pv != 0) && in_map(pa);
        off     = pa - int'(Base);
        ctrl_w  = hit && off == 0;
        restart = ctrl_w && ((pd >> 2) & 1) == 1;
        tick    = en[k] != 0 && pre[k] == m_ps[k] - 1;
        wrapnow = tick && cnt[k] == pact[k];
        aud[k]  = (en[k] != 0 && cnt[k] < cact[k]) ? vol[k] * (1 << (m_aw[k] - 3)) : 0;
        wrp[k]  = 0;
        if (restart || en[k] == 0) begin
            cnt[k] = 0; pre[k] = 0; pact[k] = psh[k]; cact[k] = csh[k];
        end else begin
            pre[k] = (pre[k] + 1) % m_ps[k];
            if (tick) begin
                if (wrapnow) begin
                    cnt[k] = 0; pact[k] = psh[k]; cact[k] = csh[k]; wrp[k] = 1;
                end else begin
                    cnt[k]++;
                end
            end
        end
        if (ctrl_w) begin
            en[k] = pd & 1;
            os[k] = (pd >> 1) & 1;
        end else if (wrapnow && os[k] != 0) begin
            en[k] = 0;
        end
        hmask = (1 << (m_pw[k] - 8)) - 1;
        if (hit) begin
            case (off)
                1: vol[k] = pd & 7;
                2: psh[k] = (psh[k] & ~255) | pd;
                3: psh[k] = (psh[k] & 255) | ((pd & hmask) << 8);
                4: csh[k] = (csh[k] & ~255) | pd;
                5: csh[k] = (csh[k] & 255) | ((pd & hmask) << 8);
                default: ;
            endcase
        end
    endtask

    function automatic int model_read(input int k, input int a);
        if (!in_map(a)) return 0;
        case (a - int'(Base))
            0: return os[k] * 2 + en[k];
            1: return vol[k];
            2: return psh[k] & 255;
            3: return psh[k] >> 8;
            4: return csh[k] & 255;
            default: return csh[k] >> 8;
        endcase
    endfunction

    task automatic check_all();
        check_eq("audio0", int'(au0), aud[0]);
        check_eq("audio1", int'(au1), aud[1]);
        check_eq("wrap0", int'(wp0), wrp[0]);
        check_eq("wrap1", int'(wp1), wrp[1]);
        check_eq("rdata0", int'(rd0), model_read(0, int'(bus_address_in)));
        check_eq("rdata1", int'(rd1), model_read(1, int'(bus_address_in)));
    endtask

    task automatic tick_cycle();
        @(posedge clk);
        for (int k = 0; k < 2; k++) step_inst(k, p_v, p_a, p_d);
        p_v = int'(bus_write); p_a = int'(bus_address_in); p_d = int'(bus_data_in);
        #1;
        check_all();
    endtask

    task automatic drive(input int off, input int d);
        bus_write      = 1'b1;
        bus_address_in = Base + 24'(off);
        bus_data_in    = 8'(d);
        tick_cycle();
        bus_write      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick_cycle();
    endtask

    task automatic measure_gap(output int n);
        n = 0;
        do begin
            tick_cycle();
            n++;
        end while (!wp0 && n < 40);
    endtask

    task automatic count_wraps(input int k, input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick_cycle();
            n += (k == 0) ? int'(wp0) : int'(wp1);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, g, bound;
        reset = 1'b0; bus_write = 1'b0; bus_address_in = Base; bus_data_in = 8'd0;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Basic tone: vol 7, period 3, cmp 2.
        drive(1, 7); drive(2, 3); drive(3, 0); drive(4, 2); drive(5, 0); drive(0, 1);
        bus_address_in = Base + 24'd1;
        measure_gap(n);
        check_eq("first_wrap_seen", int'(wp0), 1);
        check_eq("pattern_a", int'(au0), 0);
        tick_cycle(); check_eq("pattern_b", int'(au0), 224);
        tick_cycle(); check_eq("pattern_c", int'(au0), 224);
        tick_cycle(); check_eq("pattern_d", int'(au0), 0);
        check_eq("vol_read", int'(rd0), 8'h07);
        count_wraps(0, 16, n);
        check_eq("wraps_per4", n, 4);

        // Period change lands only at the next wrap.
        measure_gap(n);
        drive(2, 7);
        measure_gap(g);
        check_eq("gap_before", g + 1, 4);
        measure_gap(g);
        check_eq("gap_after", g, 8);

        // One-shot.
        drive(0, 0); drive(2, 2); drive(0, 3);
        bus_address_in = Base;
        count_wraps(0, 20, n);
        check_eq("oneshot_wraps", n, 1);
        check_eq("oneshot_enable", int'(rd0) & 1, 0);
        check_eq("oneshot_audio", int'(au0), 0);

        // Compare boundaries.
        drive(4, 0); drive(0, 1); idle(12);
        n = 0;
        for (int i = 0; i < 8; i++) begin tick_cycle(); n += (au0 != 0); end
        check_eq("cmp0_low", n, 0);
        drive(2, 3); drive(4, 5); idle(12);
        n = 0;
        for (int i = 0; i < 8; i++) begin tick_cycle(); n += (au0 == 8'd224); end
        check_eq("cmp_gt_high", n, 8);

        // Prescaled instance: period 1 with prescale 4 wraps every 8 cycles.
        drive(2, 1); idle(20);
        count_wraps(1, 32, n);
        check_eq("prescale_wraps", n, 4);

        // Restart coinciding with a wrap.
        drive(2, 3); idle(12);
        bound = 0;
        while (cnt[0] != 2 && bound < 20) begin tick_cycle(); bound++; end
        check_eq("align_cnt", cnt[0], 2);
        drive(0, 5);
        tick_cycle();
        check_eq("restart_no_wrap", int'(wp0), 0);
        check_eq("restart_enable", int'(rd0), 1);
        measure_gap(g);
        check_eq("restart_gap", g, 4);
        bus_address_in = Base + 24'd6; #1;
        check_eq("unmapped6", int'(rd0), 0);
        bus_address_in = Base - 24'd1; #1;
        check_eq("unmapped_below", int'(rd0), 0);

        // Asynchronous reset mid-tone.
        drive(2, 9); drive(4, 8); drive(0, 1); idle(14);
        bound = 0;
        while (cnt[0] != 5 && bound < 20) begin tick_cycle(); bound++; end
        check_eq("mid_tone_audio", int'(au0), 224);
        #3; reset = 1'b0; #1;
        check_eq("rst_audio0", int'(au0), 0);
        check_eq("rst_audio1", int'(au1), 0);
        check_eq("rst_wrap0", int'(wp0), 0);
        for (int o = 0; o < 6; o++) begin
            bus_address_in = Base + 24'(o); #1;
            check_eq("rst_read0", int'(rd0), 0);
            check_eq("rst_read1", int'(rd1), 0);
        end
        model_reset();
        @(negedge clk);
        reset = 1'b1;

        // Random bus traffic.
        for (int i = 0; i < 3000; i++) begin
            int off, d;
            off = int'($urandom % 8);
            if ($urandom % 4 == 0) begin
                case (off)
                    0: d = int'($urandom_range(0, 7)) | (($urandom % 4 != 0) ? 1 : 0);
                    2, 4: d = int'($urandom_range(0, 12));
                    3, 5: d = ($urandom % 8 == 0) ? int'($urandom % 256) : 0;
                    default: d = int'($urandom % 256);
                endcase
                drive(off, d);
            end else begin
                bus_address_in = ($urandom % 64 == 0) ? 24'($urandom) : Base + 24'(off);
                tick_cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sound_pwm_channel.md
Name: sound_pwm_channel

Overview:
Bus-mapped square-wave tone generator. Successor to the sound control/volume register block. Adds a parametrised period/duty timer with double-buffered reload, one-shot mode, prescaler and scaled PCM output. Sits on the CPU bus beside the other I/O register blocks and drives the audio output path.

Parameters:
BASE_ADDR, 24'h2070, address of register offset 0; block decodes BASE_ADDR+0..+5.
PERIOD_WIDTH, 16, counter/period/compare width; 9..16 (the period and compare high bytes carry PERIOD_WIDTH-8 bits).
PRESCALE, 1, clk cycles per counter tick; 1 = tick every cycle.
AUDIO_WIDTH, 8, audio_out width; >=3.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low; asserted low clears all state
bus_write  input  1  write strobe, one cycle
bus_address_in  input  24  bus address
bus_data_in  input  8  write data
bus_data_out  output  8  combinational read data
audio_out  output  AUDIO_WIDTH  PCM sample
wrap_pulse  output  1  one-cycle pulse at each counter wrap

Behaviour:
- Reset (reset low, async): all registers, counters, shadows, actives = 0; audio_out = 0; wrap_pulse = 0; write pipeline cleared.
- Register map (offset from BASE_ADDR):
  - +0 CTRL: bit0 enable, bit1 oneshot, bit2 restart (strobe, reads 0). Reads {5'd0, 0, oneshot, enable}.
  - +1 VOL: bits[2:0]. Reads {5'd0, vol}.
  - +2/+3 PERIOD shadow, low/high byte.
  - +4/+5 CMP shadow, low/high byte.
  - Other addresses: read 8'd0, writes ignored.
- Write pipeline: bus_write, address and data captured at edge N; register updated at edge N+1; one cycle write latency. Reads show shadow/register values, not actives.
- Prescaler: counts 0..PRESCALE-1 while enable=1; tick when it reaches PRESCALE-1. Held at 0 while disabled.
- Counter, on tick:
  - If counter == period_active: counter <= 0; period_active <= PERIOD shadow; cmp_active <= CMP shadow; wrap_pulse = 1 next cycle.
  - If oneshot=1 at that wrap: enable <= 0.
  - Otherwise counter increments.
- Shadow load at wrap uses shadow value before that edge. A write applied on the same edge takes effect at the next wrap.
- While enable=0: shadows copy straight into actives every cycle; counter held at 0.
- Restart: write CTRL with bit2=1. Counter and prescaler go to 0, actives reload from shadows, no wrap_pulse. Restart beats a coincident wrap. Enable/oneshot take the written bits 1:0.
- Output: tone = enable && (counter < cmp_active).
  - cmp_active = 0 gives constant low.
  - cmp_active > period_active gives constant high.
  - period_active = 0: counter stays 0 and wraps every tick.
- audio_out (registered, one cycle after tone/vol change) = tone ? (vol << (AUDIO_WIDTH-3)) : 0.
- Widths: PERIOD/CMP high-byte bits above PERIOD_WIDTH-8 are discarded on write and read as 0.

Test Plan:
- Reset low mid-tone (enable=1, counter=5) → audio_out=0, all reads 0, wrap_pulse=0 immediately, no clk edge needed.
- Write VOL=7, PERIOD=3, CMP=2, CTRL=1 (PRESCALE=1, AUDIO_WIDTH=8) → audio_out repeats 224,224,0,0; wrap_pulse every 4 cycles; read +1 returns 8'h07.
- While running, write PERIOD=7 → current period finishes at 3, then 8-cycle period; wrap_pulse spacing changes 4→8 only after first wrap.
- CTRL=3 (oneshot), PERIOD=2 → exactly one wrap_pulse, then enable reads 0 and audio_out=0.
- CMP=0 → audio_out constant 0. CMP=5 with PERIOD=3 → constant vol<<5. PRESCALE=4, PERIOD=1 → wrap_pulse every 8 cycles.
- Write CTRL=5 on the exact edge the counter wraps → counter=0, no wrap_pulse, enable stays 1. Read of unmapped BASE_ADDR+6 returns 0.
